dsram_port_arbiter: RTL and testbench

Shares the single-ported data SRAM between the ID-stage load read path and the MEM-stage store write path. Stores are absorbed into a small FIFO write buffer and drained to the SRAM in cycles the read path leaves idle. Program order is preserved: a load never observes memory older than a previously accepted store. The block sits between the pipeline stages and the `data_sram_*` top-level ports, replacing the stall-on-any-store-load-collision policy.

---
 rtl/dsram_arb_pkg.sv | 24 ++
 rtl/dsram_wbuf.sv | 83 ++++++++
 rtl/dsram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_dsram_port_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_arb_pkg.sv
// Shared types and helpers for the data-SRAM port arbiter and its store write buffer.
package dsram_arb_pkg;

    localparam int WBUF_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic        valid;
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } wbuf_entry_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                               input logic [31:0] data,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = base;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[b*8 +: 8] = data[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dsram_wbuf.sv
// Circular store buffer: enqueue/dequeue in the same cycle, word-address compare against a load,
// and an oldest-to-youngest byte merge of all hitting entries (same-cycle enqueue applied last).
module dsram_wbuf
    import dsram_arb_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enq_vld,
    input  logic [3:0]       enq_we,
    input  logic [29:0]      enq_addr,
    input  logic [31:0]      enq_wdata,
    input  logic             deq,
    input  logic [29:0]      cmp_addr,
    output wbuf_entry_t      head_entry,
    output logic [CNT_W-1:0] count,
    output logic             hit,
    output logic [3:0]       fwd_mask,
    output logic [31:0]      fwd_data
);

    wbuf_entry_t      entry_q [DEPTH];
    wbuf_entry_t      entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, idx;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (deq) begin
            entry_d[head_q].valid = 1'b0;
            head_d = head_q + 1'b1;
        end
        if (enq_vld) begin
            entry_d[tail_q] = '{valid: 1'b1, we: enq_we, addr: enq_addr, wdata: enq_wdata};
            tail_d = tail_q + 1'b1;
        end
        count_d = count_q + CNT_W'(enq_vld) - CNT_W'(deq);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Walk from the head so later (younger) stores overwrite earlier bytes.
    always_comb begin
        hit      = 1'b0;
        fwd_mask = '0;
        fwd_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (entry_q[idx].valid && entry_q[idx].addr == cmp_addr) begin
                hit      = 1'b1;
                fwd_data = byte_merge(fwd_data, entry_q[idx].wdata, entry_q[idx].we);
                fwd_mask = fwd_mask | entry_q[idx].we;
            end
        end
        if (enq_vld && enq_addr == cmp_addr) begin
            hit      = 1'b1;
            fwd_data = byte_merge(fwd_data, enq_wdata, enq_we);
            fwd_mask = fwd_mask | enq_we;
        end
    end

    assign head_entry = entry_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/dsram_port_arbiter.sv
// Single-port data SRAM shared by loads (1-cycle response) and buffered stores drained in idle cycles;
// a full buffer steals the port from loads. DSRAM_WBUF_FWD_EN forwards buffered bytes instead of stalling hits.
module dsram_port_arbiter
    import dsram_arb_pkg::*;
#(
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_ready,
    output logic        rd_rvalid,
    output logic [31:0] rd_rdata,
    input  logic        wr_req,
    input  logic [3:0]  wr_we,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_wdata,
    output logic        wr_ready,
    output logic        wbuf_empty,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

    logic [CNT_W-1:0] count;
    wbuf_entry_t      head;
    logic             hit, full, enq, deq, rd_ok;
    logic [3:0]       fwd_mask, fwd_mask_iss;
    logic [31:0]      fwd_data, rsp_data;
    logic             rd_rvalid_q, rd_rvalid_d;
    logic [3:0]       fwd_mask_q, fwd_mask_d;
    logic [31:0]      fwd_data_q, fwd_data_d, rd_rdata_q, rd_rdata_d;
    logic             unused_ok;

    assign full       = (count == CNT_W'(WBUF_DEPTH));
    assign wr_ready   = !full;
    assign wbuf_empty = (count == '0);
    assign enq        = wr_req && wr_ready;

    dsram_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk        (clk),
        .resetn     (resetn),
        .enq_vld    (enq),
        .enq_we     (wr_we),
        .enq_addr   (wr_addr[31:2]),
        .enq_wdata  (wr_wdata),
        .deq        (deq),
        .cmp_addr   (rd_addr[31:2]),
        .head_entry (head),
        .count      (count),
        .hit        (hit),
        .fwd_mask   (fwd_mask),
        .fwd_data   (fwd_data)
    );

`ifdef DSRAM_WBUF_FWD_EN
    assign rd_ok        = 1'b1;
    assign fwd_mask_iss = fwd_mask;
    assign unused_ok    = ^{wr_addr[1:0], head.valid, hit};
`else
    // A hitting load waits for the buffer to drain the matching stores.
    assign rd_ok        = !hit;
    assign fwd_mask_iss = '0;
    assign unused_ok    = ^{wr_addr[1:0], head.valid, fwd_mask};
`endif

    always_comb begin
        rd_ready        = 1'b0;
        deq             = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_we    = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (resetn) begin
            if (full) begin
                deq = 1'b1;
            end else if (rd_req && rd_ok) begin
                rd_ready       = 1'b1;
                data_sram_en   = 1'b1;
                data_sram_addr = rd_addr;
            end else if (count != '0) begin
                deq = 1'b1;
            end
        end
        if (deq) begin
            data_sram_en    = 1'b1;
            data_sram_we    = head.we;
            data_sram_addr  = {head.addr, 2'b00};
            data_sram_wdata = head.wdata;
        end
    end

    assign rsp_data = byte_merge(data_sram_rdata, fwd_data_q, fwd_mask_q);

    always_comb begin
        rd_rvalid_d = rd_req && rd_ready;
        fwd_mask_d  = rd_ready ? fwd_mask_iss : fwd_mask_q;
        fwd_data_d  = rd_ready ? fwd_data : fwd_data_q;
        rd_rdata_d  = rd_rvalid_q ? rsp_data : rd_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_rvalid_q <= 1'b0;
            fwd_mask_q  <= '0;
            fwd_data_q  <= '0;
            rd_rdata_q  <= '0;
        end else begin
            rd_rvalid_q <= rd_rvalid_d;
            fwd_mask_q  <= fwd_mask_d;
            fwd_data_q  <= fwd_data_d;
            rd_rdata_q  <= rd_rdata_d;
        end
    end

    assign rd_rvalid = rd_rvalid_q;
    assign rd_rdata  = rd_rvalid_q ? rsp_data : rd_rdata_q;

endmodule

// File: tb/tb_dsram_port_arbiter.sv
// Directed bench for dsram_port_arbiter with a synchronous SRAM model and a program-order reference memory.
module tb_dsram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ready, rd_rvalid;
    logic [31:0] rd_rdata;
    logic        wr_req;
    logic [3:0]  wr_we;
    logic [31:0] wr_addr, wr_wdata;
    logic        wr_ready, wbuf_empty;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [31:0] data_sram_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sram_wr_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    bit          mem_loaded = 1'b0;

    always #5 clk = ~clk;

    dsram_port_arbiter #(.WBUF_DEPTH(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_ready        (rd_ready),
        .rd_rvalid       (rd_rvalid),
        .rd_rdata        (rd_rdata),
        .wr_req          (wr_req),
        .wr_we           (wr_we),
        .wr_addr         (wr_addr),
        .wr_wdata        (wr_wdata),
        .wr_ready        (wr_ready),
        .wbuf_empty      (wbuf_empty),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 16) ? 32'hAAAAAAAA : (32'hC0DE0000 | 32'(i));
    endfunction

    // Synchronous SRAM, one-cycle read latency.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (data_sram_en) begin
            if (data_sram_we == 4'b0000) data_sram_rdata <= mem[data_sram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (data_sram_we[b]) mem[data_sram_addr[9:2]][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Model acceptance before the edge, check the response after it, return at the falling edge.
    task automatic tick();
        logic        acc_rd;
        logic [31:0] e;
        acc_rd = rd_req && rd_ready;
        if (wr_req && wr_ready && resetn)
            for (int b = 0; b < 4; b++)
                if (wr_we[b]) ref_mem[wr_addr[9:2]][b*8 +: 8] = wr_wdata[b*8 +: 8];
        if (acc_rd) exp_q.push_back(ref_mem[rd_addr[9:2]]);
        if (data_sram_en && data_sram_we != 4'b0000) sram_wr_cnt++;
        @(posedge clk);
        #1;
        chk("rd_rvalid", {31'b0, rd_rvalid}, {31'b0, acc_rd});
        if (rd_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_rdata", rd_rdata, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain_all();
        rd_req = 1'b0;
        wr_req = 1'b0;
        settle();
        for (int k = 0; k < 16 && wbuf_empty !== 1'b1; k++) begin
            tick();
            settle();
        end
        chk("drain_empty", {31'b0, wbuf_empty}, 32'd1);
    endtask

    initial begin
        resetn = 1'b0; rd_req = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_we = '0; wr_addr = '0; wr_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        @(posedge clk);
        @(negedge clk);

        // Reset state, with a read request held during reset.
        rd_req = 1'b1; rd_addr = 32'h200;
        settle();
        chk("rst_rd_ready", {31'b0, rd_ready}, 32'd0);
        chk("rst_sram_en", {31'b0, data_sram_en}, 32'd0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
        chk("rst_wbuf_empty", {31'b0, wbuf_empty}, 32'd1);
        chk("rst_rd_rvalid", {31'b0, rd_rvalid}, 32'd0);
        chk("rst_rd_rdata", rd_rdata, 32'd0);
        tick();
        resetn = 1'b1; rd_req = 1'b0;

        // T1: single store drains the next cycle.
        wr_req = 1'b1; wr_we = 4'hF; wr_addr = 32'h100; wr_wdata = 32'h11223344;
        settle();
        chk("t1_no_same_cycle_write", {31'b0, data_sram_en}, 32'd0);
        chk("t1_empty_same_cycle", {31'b0, wbuf_empty}, 32'd1);
        tick();
        wr_req = 1'b0;
        settle();
        chk("t1_not_empty", {31'b0, wbuf_empty}, 32'd0);
        chk("t1_en", {31'b0, data_sram_en}, 32'd1);
        chk("t1_we", {28'b0, data_sram_we}, 32'hF);
        chk("t1_addr", data_sram_addr, 32'h100);
        chk("t1_wdata", data_sram_wdata, 32'h11223344);
        tick();
        settle();
        chk("t1_empty_after", {31'b0, wbuf_empty}, 32'd1);
        rd_req = 1'b1; rd_addr = 32'h100;
        settle();
        chk("t1_readback_ready", {31'b0, rd_ready}, 32'd1);
        tick();

        // T2: fill the buffer while reads own the port.
        rd_req = 1'b1; rd_addr = 32'h200; wr_req = 1'b1; wr_we = 4'hF;
        for (int k = 0; k < 4; k++) begin
            wr_addr = 32'h300 + 32'(4 * k); wr_wdata = 32'h5000_0000 + 32'(k);
            settle();
            chk("t2_rd_ready_fill", {31'b0, rd_ready}, 32'd1);
            chk("t2_wr_ready_fill", {31'b0, wr_ready}, 32'd1);
            tick();
        end
        wr_addr = 32'h310; wr_wdata = 32'h5000_0004;
        settle();
        chk("t2_full_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("t2_full_rd_ready", {31'b0, rd_ready}, 32'd0);
        chk("t2_full_drain_addr", data_sram_addr, 32'h300);
        chk("t2_full_drain_we", {28'b0, data_sram_we}, 32'hF);
        tick();
        settle();
        chk("t2_after_drain_rd_ready", {31'b0, rd_ready}, 32'd1);
        chk("t2_after_drain_wr_ready", {31'b0, wr_ready}, 32'd1);
        tick();
        drain_all();
        rd_req = 1'b1; rd_addr = 32'h30C;
        settle();
        tick();

        // T3: partial store plus same-cycle overlapping read.
        wr_req = 1'b1; wr_we = 4'b0011; wr_addr = 32'h40; wr_wdata = 32'h0000BEEF;
        rd_req = 1'b1; rd_addr = 32'h42;
        settle();
`ifdef DSRAM_WBUF_FWD_EN
        chk("t3_fwd_rd_ready", {31'b0, rd_ready}, 32'd1);
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
`else
        chk("t3_stall_rd_ready", {31'b0, rd_ready}, 32'd0);
        chk("t3_stall_no_write", {31'b0, data_sram_en}, 32'd0);
        tick();
        wr_req = 1'b0;
        settle();
        chk("t3_drain_rd_ready", {31'b0, rd_ready}, 32'd0);
        chk("t3_drain_we", {28'b0, data_sram_we}, 32'h3);
        chk("t3_drain_addr", data_sram_addr, 32'h40);
        tick();
        settle();
        chk("t3_read_issue", {31'b0, rd_ready}, 32'd1);
        tick();
        rd_req = 1'b0;
`endif
        chk("t3_ref_word", ref_mem[16], 32'hAAAABEEF);
        drain_all();

        // T4: two buffered stores to one word, then a read of it.
        rd_req = 1'b1; rd_addr = 32'h200;
        wr_req = 1'b1; wr_we = 4'hF; wr_addr = 32'h80; wr_wdata = 32'h01010101;
        settle();
        tick();
        wr_we = 4'b1000; wr_wdata = 32'hFF000000;
        settle();
        tick();
        wr_req = 1'b0; rd_addr = 32'h80;
        settle();
`ifdef DSRAM_WBUF_FWD_EN
        chk("t4_fwd_rd_ready", {31'b0, rd_ready}, 32'd1);
`else
        chk("t4_stall_rd_ready", {31'b0, rd_ready}, 32'd0);
        for (int k = 0; k < 8 && rd_ready !== 1'b1; k++) begin
            tick();
            settle();
        end
        chk("t4_read_eventually", {31'b0, rd_ready}, 32'd1);
`endif
        tick();
        chk("t4_ref_word", ref_mem[32], 32'hFF010101);
        drain_all();

        // T5: reset with three buffered stores and a read in flight.
        rd_req = 1'b1; rd_addr = 32'h200; wr_req = 1'b1; wr_we = 4'hF;
        for (int k = 0; k < 3; k++) begin
            wr_addr = 32'h180 + 32'(4 * k); wr_wdata = 32'h7700_0000 + 32'(k);
            settle();
            tick();
        end
        wr_req = 1'b0;
        settle();
        chk("t5_buffered", {31'b0, wbuf_empty}, 32'd0);
        resetn = 1'b0;
        settle();
        tick();
        resetn = 1'b1; rd_req = 1'b0;
        settle();
        chk("t5_rvalid_dropped", {31'b0, rd_rvalid}, 32'd0);
        chk("t5_empty", {31'b0, wbuf_empty}, 32'd1);
        chk("t5_wr_ready", {31'b0, wr_ready}, 32'd1);
        sram_wr_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            settle();
            tick();
        end
        chk("t5_no_sram_writes", 32'(sram_wr_cnt), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
